// File: rtl/temp_sensor_reader.sv
// Polls a serial thermometer (8 data bits + odd parity, MSB first) and publishes a
// saturated 5-bit temperature with valid/error strobes, an error counter and a stale flag.
module temp_sensor_reader #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int STALE_LIMIT   = 3,
  parameter int TEMP_RESET    = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sysOn,
  output logic       sens_cs_n,
  output logic       sens_sclk,
  input  logic       sens_sdo,
  output logic [4:0] temperature,
  output logic       temp_valid,
  output logic       parity_err,
  output logic       stale,
  output logic [7:0] err_count
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int WAIT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CE_W   = $clog2(STALE_LIMIT + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SAMPLE_PERIOD - 1);
  localparam logic [CE_W-1:0]   CE_LIMIT  = CE_W'(STALE_LIMIT);
  localparam logic [4:0]        HALF_LAST = 5'd17;
  localparam logic [4:0]        TEMP_INIT = 5'(TEMP_RESET);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    STOP,
    UPDATE,
    WAIT
  } state_t;

  state_t              state;
  logic [DIV_W-1:0]    div_cnt;
  logic [4:0]          half_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [8:0]          shreg;
  logic [CE_W-1:0]     consec_err;
  logic                frame_good;
  logic [CE_W-1:0]     consec_next;

  function automatic logic [4:0] sat_temp(input logic [7:0] raw);
    return (raw > 8'd31) ? 5'd31 : raw[4:0];
  endfunction

  function automatic logic [7:0] sat_inc_err(input logic [7:0] cnt);
    return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  endfunction

  function automatic logic [CE_W-1:0] sat_inc_consec(input logic [CE_W-1:0] cnt);
    return (cnt >= CE_LIMIT) ? CE_LIMIT : cnt + 1'b1;
  endfunction

  // shreg holds {data[7:0], parity}; odd overall parity marks a good frame
  assign frame_good  = ^shreg;
  assign consec_next = sat_inc_consec(consec_err);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      div_cnt     <= '0;
      half_cnt    <= '0;
      wait_cnt    <= '0;
      shreg       <= '0;
      consec_err  <= '0;
      sens_cs_n   <= 1'b1;
      sens_sclk   <= 1'b0;
      temperature <= TEMP_INIT;
      temp_valid  <= 1'b0;
      parity_err  <= 1'b0;
      stale       <= 1'b1;
      err_count   <= '0;
    end else begin
      temp_valid <= 1'b0;
      parity_err <= 1'b0;
      case (state)
        IDLE: begin
          sens_cs_n <= 1'b1;
          sens_sclk <= 1'b0;
          if (sysOn) begin
            state     <= START;
            sens_cs_n <= 1'b0;
            div_cnt   <= '0;
          end
        end

        START: begin
          if (!sysOn) begin
            state     <= IDLE;
            sens_cs_n <= 1'b1;
            sens_sclk <= 1'b0;
          end else if (div_cnt == DIV_LAST) begin
            state    <= SHIFT;
            div_cnt  <= '0;
            half_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (!sysOn) begin
            state     <= IDLE;
            sens_cs_n <= 1'b1;
            sens_sclk <= 1'b0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (half_cnt == HALF_LAST) begin
              state     <= STOP;
              sens_cs_n <= 1'b1;
              sens_sclk <= 1'b0;
            end else begin
              half_cnt  <= half_cnt + 5'd1;
              sens_sclk <= ~sens_sclk;
              // data is captured on the same edge that raises sclk
              if (!sens_sclk) shreg <= {shreg[7:0], sens_sdo};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        STOP: begin
          sens_cs_n <= 1'b1;
          sens_sclk <= 1'b0;
          if (div_cnt == DIV_LAST) begin
            state   <= UPDATE;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        UPDATE: begin
          if (frame_good) begin
            temperature <= sat_temp(shreg[8:1]);
            temp_valid  <= 1'b1;
            consec_err  <= '0;
            stale       <= 1'b0;
          end else begin
            parity_err <= 1'b1;
            err_count  <= sat_inc_err(err_count);
            consec_err <= consec_next;
            if (consec_next >= CE_LIMIT) stale <= 1'b1;
          end
          wait_cnt <= '0;
          state    <= sysOn ? WAIT : IDLE;
        end

        WAIT: begin
          if (!sysOn) begin
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            state     <= START;
            sens_cs_n <= 1'b0;
            div_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state     <= IDLE;
          sens_cs_n <= 1'b1;
          sens_sclk <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temp_sensor_reader.sv
// Bench for temp_sensor_reader: serial sensor model, frame-level reference model,
// directed scenarios and randomized frames.
module tb_temp_sensor_reader;

  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 1000;
  localparam int STALE_LIMIT   = 3;
  localparam int TEMP_RESET    = 20;
  localparam int FRAME_LAT     = 20 * CLK_DIV + 1;
  localparam int SPACING       = FRAME_LAT + SAMPLE_PERIOD;
  localparam int WAIT_LIMIT    = SPACING + 200;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       sysOn    = 1'b0;
  logic       sens_sdo = 1'b0;
  logic       sens_cs_n;
  logic       sens_sclk;
  logic [4:0] temperature;
  logic       temp_valid;
  logic       parity_err;
  logic       stale;
  logic [7:0] err_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  temp_sensor_reader #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .STALE_LIMIT  (STALE_LIMIT),
    .TEMP_RESET   (TEMP_RESET)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sysOn      (sysOn),
    .sens_cs_n  (sens_cs_n),
    .sens_sclk  (sens_sclk),
    .sens_sdo   (sens_sdo),
    .temperature(temperature),
    .temp_valid (temp_valid),
    .parity_err (parity_err),
    .stale      (stale),
    .err_count  (err_count)
  );

  // Sensor: presents the MSB when selected, next bit after every sclk rise
  logic [8:0] cur_frame = '0;
  int  rises = 0;
  time last_rise_t = 0;
  time sclk_period = 0;
  always @(negedge sens_cs_n or posedge sens_sclk) begin
    if (sens_sclk === 1'b1) begin
      if (rises > 0) sclk_period = $time - last_rise_t;
      last_rise_t = $time;
      rises++;
      if (rises < 9) sens_sdo = cur_frame[8 - rises];
    end else begin
      rises = 0;
      sens_sdo = cur_frame[8];
    end
  end

  int   cyc = 0;
  int   valid_cnt = 0;
  int   perr_cnt = 0;
  int   both_cnt = 0;
  int   last_fall = -1;
  int   prev_fall = -1;
  logic cs_prev = 1'b1;
  always @(negedge clk) begin
    cyc++;
    if (temp_valid === 1'b1) valid_cnt++;
    if (parity_err === 1'b1) perr_cnt++;
    if (temp_valid === 1'b1 && parity_err === 1'b1) both_cnt++;
    if (cs_prev === 1'b1 && sens_cs_n === 1'b0) begin
      prev_fall = last_fall;
      last_fall = cyc;
    end
    cs_prev = sens_cs_n;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: state after each completed frame
  int m_temp;
  int m_err;
  int m_consec;
  bit m_stale;

  task automatic model_reset();
    m_temp   = TEMP_RESET;
    m_err    = 0;
    m_consec = 0;
    m_stale  = 1'b1;
  endtask

  task automatic model_frame(input logic [8:0] f);
    int ones;
    int data;
    ones = $countones(f);
    data = int'(f[8:1]);
    if (ones % 2 == 1) begin
      m_temp   = (data > 31) ? 31 : data;
      m_consec = 0;
      m_stale  = 1'b0;
    end else begin
      if (m_err < 255) m_err++;
      if (m_consec < STALE_LIMIT) m_consec++;
      if (m_consec >= STALE_LIMIT) m_stale = 1'b1;
    end
  endtask

  task automatic wait_cs_fall();
    int t;
    t = 0;
    while (sens_cs_n !== 1'b0 && t < WAIT_LIMIT) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= WAIT_LIMIT) begin
      errors++;
      $display("FAIL cs_fall_timeout got %0d cycles exp < %0d", t, WAIT_LIMIT);
    end
  endtask

  task automatic wait_rises(input int n);
    int t;
    t = 0;
    while (rises < n && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (t >= 400) begin
      errors++;
      $display("FAIL rise_timeout got %0d rises exp %0d", rises, n);
    end
  endtask

  // Runs one frame from cs_n fall; reports first-pulse latency and pulse widths
  task automatic run_frame(input logic [8:0] f, output int lat, output int vw, output int ew);
    cur_frame = f;
    sysOn = 1'b1;
    wait_cs_fall();
    lat = -1;
    vw  = 0;
    ew  = 0;
    for (int i = 1; i <= FRAME_LAT + 40; i++) begin
      @(posedge clk); #1;
      if (temp_valid === 1'b1) begin
        if (lat < 0) lat = i;
        vw++;
      end
      if (parity_err === 1'b1) begin
        if (lat < 0) lat = i;
        ew++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sysOn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sens_cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n got %b exp 1", sens_cs_n); end
    checks++; if (sens_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b exp 0", sens_sclk); end
    checks++; if (temperature !== 5'(TEMP_RESET)) begin errors++; $display("FAIL reset_temp got %0d exp %0d", temperature, TEMP_RESET); end
    checks++; if (stale !== 1'b1) begin errors++; $display("FAIL reset_stale got %b exp 1", stale); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err_count got %0d exp 0", err_count); end
    checks++; if (temp_valid !== 1'b0 || parity_err !== 1'b0) begin errors++; $display("FAIL reset_pulses got %b%b exp 00", temp_valid, parity_err); end
    sysOn = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_good_frame();
    int lat, vw, ew;
    run_frame({8'h17, 1'b1}, lat, vw, ew);
    model_frame({8'h17, 1'b1});
    checks++; if (lat !== FRAME_LAT) begin errors++; $display("FAIL good_latency got %0d exp %0d", lat, FRAME_LAT); end
    checks++; if (vw !== 1 || ew !== 0) begin errors++; $display("FAIL good_pulses got v%0d e%0d exp v1 e0", vw, ew); end
    checks++; if (temperature !== 5'd23) begin errors++; $display("FAIL good_temp got %0d exp 23", temperature); end
    checks++; if (stale !== 1'b0) begin errors++; $display("FAIL good_stale got %b exp 0", stale); end
    checks++; if (rises !== 9) begin errors++; $display("FAIL good_rises got %0d exp 9", rises); end
    checks++; if (sclk_period !== time'(2 * CLK_DIV * 10)) begin errors++; $display("FAIL good_sclk_period got %0t exp %0d", sclk_period, 2 * CLK_DIV * 10); end
    checks++; if (err_count !== 8'(m_err)) begin errors++; $display("FAIL good_err_count got %0d exp %0d", err_count, m_err); end
  endtask

  task automatic test_saturate();
    int lat, vw, ew;
    run_frame({8'h64, 1'b0}, lat, vw, ew);
    model_frame({8'h64, 1'b0});
    checks++; if (temperature !== 5'd31) begin errors++; $display("FAIL sat_temp got %0d exp 31", temperature); end
    checks++; if (vw !== 1 || ew !== 0 || lat !== FRAME_LAT) begin errors++; $display("FAIL sat_pulse got v%0d e%0d lat%0d exp v1 e0 lat%0d", vw, ew, lat, FRAME_LAT); end
  endtask

  task automatic test_stale();
    int lat, vw, ew;
    run_frame({8'h17, 1'b1}, lat, vw, ew);
    model_frame({8'h17, 1'b1});
    for (int k = 1; k <= 3; k++) begin
      run_frame({8'h17, 1'b0}, lat, vw, ew);
      model_frame({8'h17, 1'b0});
      checks++; if (ew !== 1 || vw !== 0 || lat !== FRAME_LAT) begin errors++; $display("FAIL bad%0d_pulse got v%0d e%0d lat%0d exp v0 e1 lat%0d", k, vw, ew, lat, FRAME_LAT); end
      checks++; if (temperature !== 5'd23) begin errors++; $display("FAIL bad%0d_temp got %0d exp 23", k, temperature); end
      checks++; if (err_count !== 8'(k)) begin errors++; $display("FAIL bad%0d_err_count got %0d exp %0d", k, err_count, k); end
      checks++; if (stale !== (k == 3)) begin errors++; $display("FAIL bad%0d_stale got %b exp %b", k, stale, (k == 3)); end
    end
    run_frame({8'h10, 1'b0}, lat, vw, ew);
    model_frame({8'h10, 1'b0});
    checks++; if (temperature !== 5'd16) begin errors++; $display("FAIL recover_temp got %0d exp 16", temperature); end
    checks++; if (stale !== 1'b0 || vw !== 1) begin errors++; $display("FAIL recover_stale got %b v%0d exp 0 v1", stale, vw); end
  endtask

  task automatic test_back_to_back();
    int lat, vw, ew;
    run_frame({8'h0A, 1'b1}, lat, vw, ew);
    model_frame({8'h0A, 1'b1});
    run_frame({8'h0B, 1'b0}, lat, vw, ew);
    model_frame({8'h0B, 1'b0});
    checks++; if (last_fall - prev_fall !== SPACING) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", last_fall - prev_fall, SPACING); end
    checks++; if (temperature !== 5'(m_temp)) begin errors++; $display("FAIL b2b_temp got %0d exp %0d", temperature, m_temp); end
  endtask

  task automatic test_abort();
    int lat, vw, ew, v0, p0;
    sysOn = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    v0 = valid_cnt;
    p0 = perr_cnt;
    cur_frame = {8'h05, 1'b1};
    sysOn = 1'b1;
    wait_cs_fall();
    wait_rises(4);
    sysOn = 1'b0;
    @(posedge clk); #1;
    checks++; if (sens_cs_n !== 1'b1 || sens_sclk !== 1'b0) begin errors++; $display("FAIL abort_bus got cs%b sclk%b exp cs1 sclk0", sens_cs_n, sens_sclk); end
    repeat (100) @(posedge clk);
    #1;
    checks++; if (valid_cnt !== v0 || perr_cnt !== p0) begin errors++; $display("FAIL abort_pulses got v%0d e%0d exp v%0d e%0d", valid_cnt, perr_cnt, v0, p0); end
    checks++; if (temperature !== 5'(m_temp) || err_count !== 8'(m_err) || stale !== m_stale) begin
      errors++; $display("FAIL abort_state got t%0d e%0d s%b exp t%0d e%0d s%b", temperature, err_count, stale, m_temp, m_err, m_stale);
    end
    run_frame({8'h05, 1'b1}, lat, vw, ew);
    model_frame({8'h05, 1'b1});
    checks++; if (temperature !== 5'd5 || vw !== 1 || lat !== FRAME_LAT || rises !== 9) begin
      errors++; $display("FAIL reenable_frame got t%0d v%0d lat%0d r%0d exp t5 v1 lat%0d r9", temperature, vw, lat, rises, FRAME_LAT);
    end
  endtask

  task automatic test_reset_mid();
    cur_frame = {8'h1F, 1'b0};
    wait_cs_fall();
    wait_rises(5);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (sens_cs_n !== 1'b1 || sens_sclk !== 1'b0) begin errors++; $display("FAIL midrst_bus got cs%b sclk%b exp cs1 sclk0", sens_cs_n, sens_sclk); end
    checks++; if (temperature !== 5'(TEMP_RESET) || stale !== 1'b1 || err_count !== 8'd0) begin
      errors++; $display("FAIL midrst_state got t%0d s%b e%0d exp t%0d s1 e0", temperature, stale, err_count, TEMP_RESET);
    end
    sysOn = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
  endtask

  task automatic test_random();
    int lat, vw, ew;
    logic [8:0] f;
    bit good;
    for (int n = 0; n < 12; n++) begin
      f = 9'($urandom_range(0, 511));
      good = ($countones(f) % 2 == 1);
      run_frame(f, lat, vw, ew);
      model_frame(f);
      checks++; if (vw !== int'(good) || ew !== int'(!good) || lat !== FRAME_LAT) begin
        errors++; $display("FAIL rnd%0d_pulse frame %h got v%0d e%0d lat%0d exp v%0d e%0d lat%0d", n, f, vw, ew, lat, good, !good, FRAME_LAT);
      end
      checks++; if (temperature !== 5'(m_temp) || stale !== m_stale || err_count !== 8'(m_err)) begin
        errors++; $display("FAIL rnd%0d_state frame %h got t%0d s%b e%0d exp t%0d s%b e%0d", n, f, temperature, stale, err_count, m_temp, m_stale, m_err);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_good_frame();
    test_saturate();
    test_stale();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_random();
    checks++; if (both_cnt !== 0) begin errors++; $display("FAIL exclusive_pulses got %0d overlaps exp 0", both_cnt); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
